mem_wb_stage: RTL

- MEM→WB pipeline stage. Accepts retiring instructions from the memory stage and selects the ALU result or load data.
- Drives write_back_en / WB_dest / WB_result into the register file.
- Holds the pipeline via a ready handshake while a load waits on a multi-cycle data memory. A wait-state timeout aborts hung loads.

---
 rtl/mem_wb_stage_pkg.sv | 20 ++
 rtl/mem_wb_stage.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_wb_stage_pkg
// Settings shared by the MEM->WB stage and the logic around it.
//   WORD_WIDTH     : datapath width
//   REG_FILE_DEPTH : register index width
//   REG_FILE_SIZE  : number of architectural registers
//   wb_state_e     : stage state encoding (IDLE=0, WAIT=1)
// ----------------------------------------------------------------------------
package mem_wb_stage_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int REG_FILE_DEPTH = 4;
    localparam int REG_FILE_SIZE  = 1 << REG_FILE_DEPTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/mem_wb_stage.sv
// ----------------------------------------------------------------------------
// mem_wb_stage
// MEM->WB pipeline stage. Retires ALU results or load data into the register
// file. While a load waits on a slow data memory the stage stalls the memory
// stage (mem_ready=0); a hung load is aborted after LOAD_TIMEOUT cycles.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   mem_valid / mem_ready          handshake with the memory stage
//   mem_wb_en, mem_r_en, mem_dest  instruction attributes
//   alu_result, mem_rdata          candidate writeback data
//   mem_rdata_valid                load data present this cycle
//   flush                          discard held / incoming instruction
//   write_back_en, WB_dest,
//   WB_result                      registered register-file write port
//   load_err                       one-cycle pulse on load timeout
//   wb_pending, pending_dest       outstanding-load info for hazard unit
// ----------------------------------------------------------------------------
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int WORD_WIDTH     = mem_wb_stage_pkg::WORD_WIDTH,
    parameter int REG_FILE_DEPTH = mem_wb_stage_pkg::REG_FILE_DEPTH,
    parameter int LOAD_TIMEOUT   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic                      mem_wb_en,
    input  logic                      mem_r_en,
    input  logic [REG_FILE_DEPTH-1:0] mem_dest,
    input  logic [WORD_WIDTH-1:0]     alu_result,
    input  logic [WORD_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_rdata_valid,
    input  logic                      flush,
    output logic                      write_back_en,
    output logic [REG_FILE_DEPTH-1:0] WB_dest,
    output logic [WORD_WIDTH-1:0]     WB_result,
    output logic                      load_err,
    output logic                      wb_pending,
    output logic [REG_FILE_DEPTH-1:0] pending_dest
);

    localparam int CW = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    wb_state_e                 state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      wbe_q, wbe_d;
    logic [REG_FILE_DEPTH-1:0] dest_q, dest_d;
    logic [WORD_WIDTH-1:0]     res_q, res_d;
    logic                      err_q, err_d;
    logic                      lat_wb_q, lat_wb_d;
    logic [REG_FILE_DEPTH-1:0] lat_dest_q, lat_dest_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wbe_d      = 1'b0;          // strobe lasts exactly one cycle per retire
        dest_d     = dest_q;
        res_d      = res_q;
        err_d      = 1'b0;
        lat_wb_d   = lat_wb_q;
        lat_dest_d = lat_dest_q;

        case (state_q)
            ST_IDLE: begin
                // flush beats an incoming transfer: the instruction is dropped
                if (mem_valid && !flush) begin
                    if (!mem_r_en) begin
                        wbe_d  = mem_wb_en;
                        dest_d = mem_dest;
                        res_d  = alu_result;
                    end else if (mem_rdata_valid) begin
                        wbe_d  = mem_wb_en;
                        dest_d = mem_dest;
                        res_d  = mem_rdata;
                    end else begin
                        lat_wb_d   = mem_wb_en;
                        lat_dest_d = mem_dest;
                        state_d    = ST_WAIT;
                        cnt_d      = CNT_ONE;
                    end
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    // flush wins even over arriving load data
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (mem_rdata_valid) begin
                    wbe_d   = lat_wb_q;
                    dest_d  = lat_dest_q;
                    res_d   = mem_rdata;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wbe_q      <= 1'b0;
            dest_q     <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
            lat_wb_q   <= 1'b0;
            lat_dest_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wbe_q      <= wbe_d;
            dest_q     <= dest_d;
            res_q      <= res_d;
            err_q      <= err_d;
            lat_wb_q   <= lat_wb_d;
            lat_dest_q <= lat_dest_d;
        end
    end

    assign mem_ready     = (state_q == ST_IDLE) && !rst;
    assign write_back_en = wbe_q;
    assign WB_dest       = dest_q;
    assign WB_result     = res_q;
    assign load_err      = err_q;
    assign wb_pending    = (state_q == ST_WAIT) && lat_wb_q;
    assign pending_dest  = lat_dest_q;

endmodule
